// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed hex display driver with dead time, PWM dimming, blink and leading-zero blanking
// Ports: clk/reset (async, active-high); encoded/digit_point/blank_lz/blink_mask are latched once per frame;
// brightness is used live; anode/cathode/dp drive the display; frame_start pulses as each frame begins.
module seven_segment_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYCLES = 25000,
  parameter int DEAD_CYCLES = 2,
  parameter int PWM_BITS = 4,
  parameter int BLINK_FRAMES = 250,
  parameter bit ANODE_ACTIVE_LOW = 1,
  parameter bit CATHODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS*4-1:0] encoded,
  input  logic [NUM_DIGITS-1:0]   digit_point,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic AL = ANODE_ACTIVE_LOW;
  localparam logic CL = CATHODE_ACTIVE_LOW;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] digit;
  logic [PWM_BITS-1:0] pwm;
  logic [FW-1:0] frame_cnt;
  logic blink_off, run;
  logic [NUM_DIGITS*4-1:0] sh_enc;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blink, lz;
  logic sh_blz, nz, last_slot, last, active;
  logic [3:0] val;
  logic [6:0] seg;
  assign last_slot = slot_cnt == SW'(SLOT_CYCLES - 1);
  assign last = last_slot && digit == DW'(NUM_DIGITS - 1);
  assign val = sh_enc[{digit, 2'b00} +: 4];
  assign active = run && slot_cnt >= SW'(DEAD_CYCLES) && pwm < brightness && !(blink_off && sh_blink[digit]);
  assign seg = lz[digit] ? 7'h00 : SEG[val];
  // lz[k] marks digit k as a leading zero: it and every digit above it hold 0
  always_comb begin
    lz = '0;
    nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      nz = nz | (sh_enc[4*k +: 4] != 4'd0);
      lz[k] = sh_blz & ~nz;
    end
  end
  // run is low only on the first edge after reset, which loads the shadow and opens frame 0
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      slot_cnt <= '0;
      digit <= '0;
      pwm <= '0;
      frame_cnt <= '0;
      blink_off <= 1'b0;
      run <= 1'b0;
      sh_enc <= '0;
      sh_dp <= '0;
      sh_blink <= '0;
      sh_blz <= 1'b0;
      anode <= {NUM_DIGITS{AL}};
      cathode <= {7{CL}};
      dp <= CL;
      frame_start <= 1'b0;
    end else begin
      pwm <= pwm + 1'b1;
      run <= 1'b1;
      frame_start <= !run || last;
      if (!run || last) begin
        sh_enc <= encoded;
        sh_dp <= digit_point;
        sh_blink <= blink_mask;
        sh_blz <= blank_lz;
      end
      if (run) begin
        slot_cnt <= last_slot ? '0 : slot_cnt + 1'b1;
        if (last_slot) digit <= digit == DW'(NUM_DIGITS - 1) ? '0 : digit + 1'b1;
        if (last) begin
          frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
          if (frame_cnt == FW'(BLINK_FRAMES - 1)) blink_off <= ~blink_off;
        end
      end
      anode <= {NUM_DIGITS{AL}} ^ (active ? NUM_DIGITS'(1) << digit : '0);
      cathode <= {7{CL}} ^ (active ? seg : 7'h00);
      dp <= CL ^ (active & sh_dp[digit]);
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: random stimulus against a cycle-arithmetic reference of the scan driver
module tb_seven_segment_scan;
  localparam int N = 4, S = 8, F = N * S;
  logic clk = 0, reset = 1;
  logic [15:0] enc = 0;
  logic [3:0] dpt = 0, bm = 0;
  logic [1:0] br = 0;
  logic blz = 0;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic dp, frame_start;
  int n_tests = 0, n_fail = 0;
  bit checking = 0, started = 0;
  int c = 0;
  logic [15:0] s_enc = 0;
  logic [3:0] s_dp = 0, s_bm = 0;
  logic s_blz = 0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_cat = 7'h7F;
  logic exp_dp = 1, exp_fs = 0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_scan #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .DEAD_CYCLES(1), .PWM_BITS(2),
    .BLINK_FRAMES(2), .ANODE_ACTIVE_LOW(1), .CATHODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .encoded(enc), .digit_point(dpt), .brightness(br),
    .blank_lz(blz), .blink_mask(bm), .anode(anode), .cathode(cathode), .dp(dp),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snap();
    s_enc = enc;
    s_dp = dpt;
    s_bm = bm;
    s_blz = blz;
  endtask

  // Cycle c after the start edge holds slot c%S, digit (c/S)%N, frame c/F, pwm (c+1)%4;
  // outputs seen after an edge describe the cycle that edge ended.
  task automatic model_step();
    int slot, dig, pwm, f;
    bit on, blank;
    logic [6:0] seg;
    if (reset) begin
      started = 0;
      exp_an = 4'hF; exp_cat = 7'h7F; exp_dp = 1; exp_fs = 0;
    end else if (!started) begin
      started = 1;
      c = 0;
      snap();
      exp_an = 4'hF; exp_cat = 7'h7F; exp_dp = 1; exp_fs = 1;
    end else begin
      slot = c % S;
      dig = (c / S) % N;
      pwm = (c + 1) % 4;
      f = c / F;
      on = slot >= 1 && pwm < int'(br) && !(((f / 2) % 2 == 1) && s_bm[dig]);
      blank = s_blz && dig != 0 && (s_enc >> (4 * dig)) == 0;
      seg = blank ? 7'h00 : seg_tab[(s_enc >> (4 * dig)) & 16'hF];
      exp_an = on ? ~(4'b1 << dig) : 4'hF;
      exp_cat = on ? ~seg : 7'h7F;
      exp_dp = on ? ~s_dp[dig] : 1'b1;
      c++;
      exp_fs = (c % F) == 0;
      if (exp_fs) snap();
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("anode", anode, exp_an);
      check("cathode", cathode, exp_cat);
      check("dp", dp, exp_dp);
      check("frame_start", frame_start, exp_fs);
    end
  end

  task automatic randomize_inputs();
    case ($urandom_range(0, 3))
      0: enc = 16'($urandom);
      1: enc = 16'($urandom_range(0, 15));
      2: enc = 16'h0;
      default: enc = 16'($urandom_range(0, 255));
    endcase
    br = 2'($urandom);
    blz = 1'($urandom);
    bm = 4'($urandom);
    dpt = 4'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checking = 1;
    enc = 16'h1234; br = 2'd3; dpt = 4'b0100;
    reset = 0;
    repeat (4 * F) @(negedge clk);
    bm = 4'b0001; enc = 16'h0005; blz = 1;
    repeat (7 * F) @(negedge clk);
    for (int p = 0; p < 30; p++) begin
      randomize_inputs();
      repeat ($urandom_range(10, 150)) @(negedge clk);
      if (p == 15) begin
        @(negedge clk);
        #2 reset = 1;
        #1 check("reset_anode", anode, 32'hF);
        check("reset_cathode", cathode, 32'h7F);
        check("reset_fs", frame_start, 32'h0);
        repeat (3) @(negedge clk);
        reset = 0;
      end
    end
    br = 2'd0;
    repeat (F) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter SLOT_CYCLES, default 25000, clocks each digit is selected (>= 4).
REQ-003 Parameter DEAD_CYCLES, default 2, clocks at start of each slot with all anodes off (< SLOT_CYCLES).
REQ-004 Parameter PWM_BITS, default 4, brightness resolution.
REQ-005 Parameter BLINK_FRAMES, default 250, frames per blink half-period.
REQ-006 Parameter ANODE_ACTIVE_LOW, default 1; parameter CATHODE_ACTIVE_LOW, default 1; polarity of the respective outputs.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 encoded  input  NUM_DIGITS x 4  hex value per digit; index 0 is rightmost.
REQ-010 digit_point  input  NUM_DIGITS  decimal point request per digit.
REQ-011 brightness  input  PWM_BITS  display duty level.
REQ-012 blank_lz  input  1  enable leading-zero blanking.
REQ-013 blink_mask  input  NUM_DIGITS  digits to blink.
REQ-014 anode  output  NUM_DIGITS  digit select, one-hot when active.
REQ-015 cathode  output  7  segments g..a (bit 6 = g).
REQ-016 dp  output  1  decimal point segment.
REQ-017 frame_start  output  1  one-cycle pulse at start of every frame.

Function
REQ-018 Slot counter counts 0..SLOT_CYCLES-1 then wraps; on wrap, digit index increments mod NUM_DIGITS.
REQ-019 Frame = NUM_DIGITS slots; frame start = slot counter 0 with digit index 0.
REQ-020 encoded, digit_point, blank_lz, blink_mask latch into a frame shadow register on the clock ending the last slot; display uses shadow only (no tearing mid-frame); brightness is used live.
REQ-021 frame_start asserts in the cycle the shadow load takes effect (slot 0, count 0), high exactly one cycle.
REQ-022 Hex decode: standard 0-F patterns (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71), active-high before polarity.
REQ-023 Leading-zero blanking: when shadow blank_lz=1, digit k blanked if shadow value of digit k and all higher digits is 0; digit 0 never blanked; blanked digit shows no segments but its dp still shows.
REQ-024 Free-running PWM counter, PWM_BITS wide, increments every clock, wraps.
REQ-025 Anode for current digit active iff slot count >= DEAD_CYCLES, PWM counter < brightness, and digit not in blink-off; otherwise all anodes inactive.
REQ-026 brightness=0 -> anodes never active; brightness=2^PWM_BITS-1 -> (2^PWM_BITS-1)/2^PWM_BITS duty within non-dead cycles.
REQ-027 Blink: frame counter toggles blink phase every BLINK_FRAMES frames; phase starts "on"; during "off" phase, digits in shadow blink_mask dark.
REQ-028 cathode and dp carry current digit's pattern whenever anode is active; when all anodes inactive, cathode and dp are driven to the off level.
REQ-029 All outputs registered; outputs reflect counter state with exactly one clock latency.
REQ-030 Polarity: anode inverted when ANODE_ACTIVE_LOW=1; cathode and dp inverted when CATHODE_ACTIVE_LOW=1.
REQ-031 Counter widths are $clog2 of their ranges (minimum 1 bit); no overflow beyond stated wrap points.

Reset
REQ-032 While reset high: slot, digit, PWM, frame counters 0; blink phase on; shadow registers 0; anode all inactive; cathode, dp off level; frame_start 0.
REQ-033 Reset asserted mid-frame takes effect immediately (asynchronously); after deassertion, first frame_start occurs one clock later with shadow loaded from inputs sampled at the deassertion edge.

Verification
REQ-034 NUM_DIGITS=4, SLOT_CYCLES=8, DEAD_CYCLES=1, PWM_BITS=2, brightness=3, encoded=1234h -> anode active-low 1110,1101,1011,0111 in order, cathode ~06,~4F? per digit decode (4,3,2,1 -> ~66,~4F,~5B,~06), dark 1 of 8 slot cycles, dark when PWM=3.
REQ-035 encoded=0005h, blank_lz=1 -> digits 3..1 no segments, digit 0 shows ~6D; encoded=0000h -> digit 0 shows ~3F.
REQ-036 Change encoded mid-frame from 1111h to 2222h -> remaining slots of frame still show 1, next frame after frame_start shows 2.
REQ-037 brightness=0 -> anode stays 1111 for a full frame; brightness=1 -> anode active 1 of every 4 clocks outside dead cycles.
REQ-038 BLINK_FRAMES=2, blink_mask=0001 -> digit 0 dark for frames 2-3, lit for frames 0-1 and 4-5; other digits unaffected.
REQ-039 Assert reset for 3 cycles mid-slot -> outputs go inactive same cycle, frame_start pulses one clock after release, scan restarts at digit 0.
